// File: rtl/ssd_display_arbiter.sv
// ssd_display_arbiter
//   Shares one 8-digit seven-segment display between NUM_REQ requesters.
//   Round-robin arbitration with a minimum dwell time. A granted source keeps
//   the display until it drops its request, or until its dwell has expired
//   and another source is waiting. data_out/control_out are registered and
//   feed seven_segment8_wrapper directly (control_out = {blank, dp[7:0]}).
//
//   Optional build macro: SSD_ARB_BLANK_GAP_EN
//     When it is defined, every hand-over (switch or release) passes through a
//     blanked GAP of GAP_CYCLES clocks. After the GAP the block re-arbitrates
//     from ptr among the requests asserted at that time.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   req          per-source request, level sensitive
//   data_in      per-source hex digits, source i at [32i+31:32i]
//   dp_in        per-source decimal points, source i at [8i+7:8i]
//   grant        one-hot grant, or all zero
//   data_out     display digits to the wrapper
//   control_out  {blank, dp[7:0]} to the wrapper
//   busy         high while any grant is active
module ssd_display_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned DWELL_CYCLES = 50_000_000,
   parameter int unsigned GAP_CYCLES   = 1_000_000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*32-1:0]  data_in,
   input  logic [NUM_REQ*8-1:0]   dp_in,
   output logic [NUM_REQ-1:0]     grant,
   output logic [31:0]            data_out,
   output logic [8:0]             control_out,
   output logic                   busy
);

   localparam int unsigned IDX_W   = $clog2(NUM_REQ);
   // One counter serves both the dwell and the gap, so size it for the larger.
   localparam int unsigned CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
`ifdef SSD_ARB_BLANK_GAP_EN
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
`endif
   localparam logic [8:0]       BLANK      = 9'h100;

   typedef logic [IDX_W-1:0] idx_t;

`ifdef SSD_ARB_BLANK_GAP_EN
   typedef enum logic [1:0] {StIdle, StShow, StGap} state_t;
`else
   typedef enum logic [1:0] {StIdle, StShow} state_t;
`endif

   state_t           state_q;
   idx_t             ptr_q;
   idx_t             owner_q;
   logic [CNT_W-1:0] cnt_q;

   logic             idle_hit;
   idx_t             idle_idx;
   logic             sw_hit;
   idx_t             sw_idx;
   logic [31:0]      owner_data;
   logic [7:0]       owner_dp;

   function automatic idx_t wrap_add(idx_t base, int unsigned off);
      int unsigned s;
      s = (32'(base) + off) % NUM_REQ;
      return idx_t'(s);
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(idx_t i);
      logic [NUM_REQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Scan offsets from the far end back to the near end so the last hit
   // written is the closest one in round-robin order.
   always_comb begin
      idle_hit = 1'b0;
      idle_idx = ptr_q;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[wrap_add(ptr_q, unsigned'(k))]) begin
            idle_hit = 1'b1;
            idle_idx = wrap_add(ptr_q, unsigned'(k));
         end
      end
   end

   // Next requester after the current owner, excluding the owner itself.
   always_comb begin
      sw_hit = 1'b0;
      sw_idx = owner_q;
      for (int k = NUM_REQ - 1; k >= 1; k--) begin
         if (req[wrap_add(owner_q, unsigned'(k))]) begin
            sw_hit = 1'b1;
            sw_idx = wrap_add(owner_q, unsigned'(k));
         end
      end
   end

   always_comb begin
      owner_data = '0;
      owner_dp   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == idx_t'(i)) begin
            owner_data = data_in[i*32 +: 32];
            owner_dp   = dp_in[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         grant       <= '0;
         data_out    <= '0;
         control_out <= BLANK;
      end else begin
         case (state_q)
            StIdle: begin
               data_out    <= '0;
               control_out <= BLANK;
               if (idle_hit) begin
                  state_q <= StShow;
                  owner_q <= idle_idx;
                  grant   <= onehot(idle_idx);
                  cnt_q   <= '0;
               end
            end

            StShow: begin
               data_out    <= owner_data;
               control_out <= {1'b0, owner_dp};
               if (!req[owner_q]) begin
                  // Release wins over a coincident dwell expiry.
                  grant       <= '0;
                  ptr_q       <= wrap_add(owner_q, 32'd1);
                  cnt_q       <= '0;
                  data_out    <= '0;
                  control_out <= BLANK;
`ifdef SSD_ARB_BLANK_GAP_EN
                  state_q     <= StGap;
`else
                  state_q     <= StIdle;
`endif
               end else if (cnt_q == DWELL_LAST && sw_hit) begin
`ifdef SSD_ARB_BLANK_GAP_EN
                  grant       <= '0;
                  ptr_q       <= wrap_add(owner_q, 32'd1);
                  cnt_q       <= '0;
                  data_out    <= '0;
                  control_out <= BLANK;
                  state_q     <= StGap;
`else
                  // Direct hand-over: grant moves without an all-zero cycle.
                  owner_q <= sw_idx;
                  grant   <= onehot(sw_idx);
                  ptr_q   <= wrap_add(sw_idx, 32'd1);
                  cnt_q   <= '0;
`endif
               end else if (cnt_q != DWELL_LAST) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

`ifdef SSD_ARB_BLANK_GAP_EN
            StGap: begin
               data_out    <= '0;
               control_out <= BLANK;
               if (cnt_q == GAP_LAST) begin
                  cnt_q <= '0;
                  if (idle_hit) begin
                     state_q <= StShow;
                     owner_q <= idle_idx;
                     grant   <= onehot(idle_idx);
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`endif

            default: begin
               state_q     <= StIdle;
               grant       <= '0;
               data_out    <= '0;
               control_out <= BLANK;
            end
         endcase
      end
   end

   assign busy = |grant;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Scoreboard bench for ssd_display_arbiter (NUM_REQ=4, DWELL=8, GAP=4).
// The stimulus process pushes the expected output state after each clock
// edge; the monitor pops one entry per falling edge and compares.
module tb_ssd_display_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [3:0]   req = '0;
   logic [127:0] data_in;
   logic [31:0]  dp_in;
   logic [3:0]   grant;
   logic [31:0]  data_out;
   logic [8:0]   control_out;
   logic         busy;

   typedef struct {
      string       tag;
      logic [3:0]  g;
      logic        chk;
      logic [31:0] d;
      logic [8:0]  c;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   logic [31:0] dat [4] = '{32'h1111_0000, 32'h1234_ABCD, 32'h2222_2222, 32'hDEAD_BEEF};
   logic [7:0]  dpv [4] = '{8'h10, 8'h81, 8'h22, 8'h3C};

   ssd_display_arbiter #(
      .NUM_REQ      (4),
      .DWELL_CYCLES (8),
      .GAP_CYCLES   (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .data_in     (data_in),
      .dp_in       (dp_in),
      .grant       (grant),
      .data_out    (data_out),
      .control_out (control_out),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(string tag, logic [3:0] g, logic chk, logic [31:0] d,
                               logic [8:0] c);
      exp_t e;
      e.tag = tag; e.g = g; e.chk = chk; e.d = d; e.c = c;
      return e;
   endfunction

   function automatic exp_t blank_e(string tag);
      return mk(tag, 4'b0000, 1'b1, 32'h0, 9'h100);
   endfunction

   function automatic exp_t gnt_e(string tag, logic [3:0] g);
      return mk(tag, g, 1'b0, 32'h0, 9'h100);
   endfunction

   // Grant just rose out of IDLE/GAP: outputs still blanked for this cycle.
   function automatic exp_t new_e(string tag, logic [3:0] g);
      return mk(tag, g, 1'b1, 32'h0, 9'h100);
   endfunction

   function automatic exp_t show_e(string tag, logic [3:0] g, int i);
      return mk(tag, g, 1'b1, dat[i], {1'b0, dpv[i]});
   endfunction

   task automatic tick(input exp_t e);
      @(posedge clk);
      #1;
      sb.push_back(e);
   endtask

   task automatic ticks(input int n, input exp_t e);
      for (int i = 0; i < n; i++) tick(e);
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (grant !== e.g) begin
               failures++;
               $display("FAIL %s grant got=%b exp=%b", e.tag, grant, e.g);
            end
            checks++;
            if (busy !== (|e.g)) begin
               failures++;
               $display("FAIL %s busy got=%b exp=%b", e.tag, busy, |e.g);
            end
            if (e.chk) begin
               checks++;
               if (data_out !== e.d) begin
                  failures++;
                  $display("FAIL %s data_out got=%h exp=%h", e.tag, data_out, e.d);
               end
               checks++;
               if (control_out !== e.c) begin
                  failures++;
                  $display("FAIL %s control_out got=%h exp=%h", e.tag, control_out, e.c);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout sim_time got=%0t exp=<1000000", $time);
      $fatal(1, "timeout");
   end

   initial begin
      data_in = {dat[3], dat[2], dat[1], dat[0]};
      dp_in   = {dpv[3], dpv[2], dpv[1], dpv[0]};

      // Reset held, then released.
      ticks(2, blank_e("in_reset"));
      rst = 1'b1;

      // 1: idle with no requests.
      ticks(20, blank_e("idle"));

      // 2: single requester 1.
      req = 4'b0010;
      tick(new_e("grant1_rise", 4'b0010));
      ticks(50, show_e("show1", 4'b0010, 1));

      // 5: asynchronous reset between edges.
      @(posedge clk);
      #2;
      rst = 1'b0;
      sb.push_back(blank_e("async_reset"));
      tick(blank_e("reset_hold"));
      req = 4'b1111;
      rst = 1'b1;
      tick(new_e("restart_req0", 4'b0001));
      tick(show_e("restart_show0", 4'b0001, 0));

`ifndef SSD_ARB_BLANK_GAP_EN
      req = 4'b0000;
      tick(gnt_e("release0", 4'b0000));
      tick(blank_e("idle_a"));

      // 3: dwell, then round-robin switch 1 -> 3 -> 0.
      req = 4'b0010;
      tick(gnt_e("own1", 4'b0010));
      tick(show_e("own1_c1", 4'b0010, 1));
      req = 4'b1011;
      ticks(6, show_e("no_preempt", 4'b0010, 1));
      tick(gnt_e("switch_to3", 4'b1000));
      ticks(7, show_e("own3_dwell", 4'b1000, 3));
      tick(gnt_e("switch_to0", 4'b0001));
      tick(show_e("own0_show", 4'b0001, 0));

      // 4a: owner drops early while req0 waits.
      req = 4'b0000;
      tick(gnt_e("release0b", 4'b0000));
      tick(blank_e("idle_b"));
      req = 4'b0010;
      tick(gnt_e("own1_b", 4'b0010));
      req = 4'b0011;
      ticks(3, show_e("own1_c3", 4'b0010, 1));
      req = 4'b0001;
      tick(gnt_e("early_release", 4'b0000));
      tick(new_e("regrant0", 4'b0001));

      // 4b: owner drops on the dwell-expiry cycle.
      req = 4'b1001;
      ticks(7, show_e("own0_dwell", 4'b0001, 0));
      req = 4'b1000;
      tick(gnt_e("expiry_release", 4'b0000));
      tick(new_e("after_expiry_rel", 4'b1000));

      // ptr after releasing owner 1 favours 2 over 0.
      req = 4'b0000;
      tick(gnt_e("release3", 4'b0000));
      tick(blank_e("idle_c"));
      req = 4'b0010;
      tick(gnt_e("own1_c", 4'b0010));
      req = 4'b0101;
      tick(gnt_e("release1", 4'b0000));
      tick(gnt_e("ptr_honoured", 4'b0100));
`else
      // 6: blanked gap on every hand-over.
      req = 4'b0000;
      ticks(6, blank_e("gap_release"));
      req = 4'b0010;
      tick(new_e("gap_own1", 4'b0010));
      req = 4'b1010;
      ticks(7, show_e("gap_own1_dwell", 4'b0010, 1));
      ticks(4, blank_e("gap_blank"));
      tick(new_e("gap_grant3", 4'b1000));
      tick(show_e("gap_show3", 4'b1000, 3));
`endif

      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain pending got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
